// File: rtl/ns_pkg.sv
// rtl/ns_pkg.sv - shared beat type and one-hot helper for the ns_* mux/demux family
package ns_pkg;

    localparam int NS_DATA_W      = 3;
    localparam int NS_SEL_W       = 8;
    localparam int NS_ONEHOT_MAXW = 64;

    typedef struct packed {
        logic [NS_DATA_W-1:0] data;
        logic [NS_SEL_W-1:0]  sel;
    } ns_beat_t;

    // Callers zero-extend narrower selects; zero-extension preserves one-hotness.
    function automatic logic ns_is_onehot(input logic [NS_ONEHOT_MAXW-1:0] v);
        return (v != '0) && ((v & (v - NS_ONEHOT_MAXW'(1))) == '0);
    endfunction

endpackage

// File: rtl/ns_skid_buf.sv
// rtl/ns_skid_buf.sv - generic 2-entry valid/ready skid buffer with registered outputs
module ns_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_m_vld;
    logic [WIDTH-1:0] r_m_data;
    logic             r_s_vld;
    logic [WIDTH-1:0] r_s_data;
    logic             w_in_fire;
    logic             w_out_fire;

    // Ready looks only at the skid flag, so there is no path from i_ready.
    assign o_ready    = ~r_s_vld;
    assign w_in_fire  = i_valid & o_ready;
    assign w_out_fire = r_m_vld & i_ready;
    assign o_valid    = r_m_vld;
    assign o_data     = r_m_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_vld  <= 1'b0;
            r_m_data <= '0;
            r_s_vld  <= 1'b0;
            r_s_data <= '0;
        end else if (!r_m_vld) begin
            if (w_in_fire) begin
                r_m_vld  <= 1'b1;
                r_m_data <= i_data;
            end
        end else if (w_out_fire) begin
            if (r_s_vld) begin
                r_m_data <= r_s_data;
                r_s_vld  <= 1'b0;
            end else if (w_in_fire) begin
                r_m_data <= i_data;
            end else begin
                r_m_vld  <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_s_vld  <= 1'b1;
            r_s_data <= i_data;
        end
    end

endmodule

// File: rtl/ns_demux1h.sv
// rtl/ns_demux1h.sv - registered one-hot demultiplexer with illegal-select filtering
module ns_demux1h
    import ns_pkg::*;
#(
    parameter int DATA_WIDTH = NS_DATA_W,
    parameter int SEL_WIDTH  = NS_SEL_W,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]  in_sel,
    output logic [SEL_WIDTH-1:0]  out_valid,
    input  logic [SEL_WIDTH-1:0]  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  err_pulse,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam int PAY_W = DATA_WIDTH + SEL_WIDTH;

    logic [NS_ONEHOT_MAXW-1:0] w_sel_ext;
    logic                      w_legal;
    logic                      w_in_fire;
    logic                      w_drop;
    logic                      w_m_vld;
    logic                      w_out_accept;
    logic [PAY_W-1:0]          w_m_pay;
    logic [DATA_WIDTH-1:0]     w_m_data;
    logic [SEL_WIDTH-1:0]      w_m_sel;
    logic                      r_err_pulse;
    logic [CNT_WIDTH-1:0]      r_err_cnt;

    always_comb begin
        w_sel_ext                = '0;
        w_sel_ext[SEL_WIDTH-1:0] = in_sel;
    end

    assign w_legal   = ns_is_onehot(w_sel_ext);
    assign w_in_fire = in_valid & in_ready;
    // Illegal beats complete the handshake but are never offered to the buffer.
    assign w_drop    = w_in_fire & ~w_legal;

    ns_skid_buf #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid & w_legal),
        .o_ready (in_ready),
        .i_data  ({in_data, in_sel}),
        .o_valid (w_m_vld),
        .i_ready (w_out_accept),
        .o_data  (w_m_pay)
    );

    assign {w_m_data, w_m_sel} = w_m_pay;
    assign out_valid           = w_m_vld ? w_m_sel : '0;
    assign out_data            = w_m_data;
    // Ready bits of non-selected channels are masked out by out_valid.
    assign w_out_accept        = |(out_valid & out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_err_pulse <= w_drop;
            if (w_drop && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;

endmodule

// File: doc/ns_demux1h.md
# ns_demux1h

Registered one-hot demultiplexer with a valid/ready handshake. It is the sending-side counterpart of `ns_mux1h`. It accepts one beat per cycle, carrying a data word and a one-hot destination flag, and presents the word to exactly one of `SEL_WIDTH` downstream channels. A 2-entry skid buffer keeps full throughput with registered outputs. Beats with a select that is not one-hot are dropped and counted, so that no malformed select ever reaches an `ns_mux1h` downstream.

## Interface
- `DATA_WIDTH`, 3: payload width in bits.
- `SEL_WIDTH`, 8: number of destination channels, and the width of the one-hot select.
- `CNT_WIDTH`, 8: width of the saturating error counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  DATA_WIDTH  payload.
- `in_sel`  in  SEL_WIDTH  one-hot destination flag.
- `out_valid`  out  SEL_WIDTH  per-channel valid; at most one bit set.
- `out_ready`  in  SEL_WIDTH  per-channel ready.
- `out_data`  out  DATA_WIDTH  payload, shared by all channels.
- `err_pulse`  out  1  one-cycle pulse for each dropped illegal beat.
- `err_cnt`  out  CNT_WIDTH  saturating count of dropped beats.

## Operation
**Storage**
- Main register: `m_vld`, `m_data`, `m_sel`.
- Skid register: `s_vld`, `s_data`, `s_sel`.

**Handshake signals**
- Input transfer: `in_fire = in_valid & in_ready`.
- `in_ready = !s_vld`. This depends on register state only; there is no combinational path from `out_ready`.
- Output accept: `out_fire = m_vld & |(out_valid & out_ready)`.
- `out_valid = m_vld ? m_sel : '0`.
- `out_data = m_data`.
- `out_ready` bits of non-selected channels are ignored.

**Legality check**
- `legal = (popcount(in_sel) == 1)`.
- An illegal beat still completes the input handshake, then is discarded.
- A discarded beat never occupies main or skid.
- It sets `err_pulse` on the next cycle and increments `err_cnt`.
- `err_cnt` saturates at `2^CNT_WIDTH-1`.

**Buffer update rules** (`L = in_fire & legal`)
- Main empty, L: load main from the input.
- Main full and `out_fire`, skid full: main loads from skid; skid is cleared.
  - `in_ready` was 0 in this cycle, so L is impossible here.
- Main full and `out_fire`, skid empty, L: main loads from the input.
- Main full and `out_fire`, skid empty, no L: main is cleared.
- Main full, no `out_fire`, L: skid loads from the input.
  - Skid must be empty here, which `in_ready` guarantees.
- Main full, no `out_fire`, no L: hold.

**Ordering and stability**
- Ordering is strict FIFO across all channels.
- A beat for channel j blocks later beats for any channel until channel j accepts it.
- `out_valid`, `out_data` and `m_sel` are stable while stalled.
- Once asserted, `out_valid` deasserts only after acceptance.

**Upstream rule**
- Upstream holds `in_data` and `in_sel` stable while `in_valid & !in_ready`.

## Timing
- Reset values while `rst_n` = 0:
  - `m_vld` and `s_vld` are 0.
  - `out_valid` = 0, `out_data` = 0, `in_ready` = 1.
  - `err_pulse` = 0, `err_cnt` = 0.
- Reset asserted mid-operation discards both entries immediately (asynchronous). There is no partial-beat recovery.
- Latency: a legal `in_fire` in cycle t gives `out_valid` in cycle t+1 when main is empty or is accepted in cycle t.
- Throughput: 1 beat/cycle with `out_ready` held high on the target channels.
- Backpressure: after 2 buffered beats with no acceptance, `in_ready` drops on the next cycle. It reasserts the cycle after the first `out_fire`.
- `err_pulse`: asserted in cycle t+1 for an illegal `in_fire` in cycle t. `err_cnt` updates on the same edge.

## Structure
- Package `ns_pkg`:
  - Function `ns_is_onehot` (generic width, via parameterised class or localparam-sized function), shared with `ns_mux1h` assertions.
  - Beat struct typedef: data + sel.
- Sub-module `ns_skid_buf`: generic 2-entry valid/ready skid buffer, parameterised by payload width. `ns_demux1h` instantiates it with payload {data, sel} and wraps the legality filter and the one-hot output fan-out.

## Test plan
- **Single beat.** After reset, drive `in_data`=5, `in_sel`=8'h40, all `out_ready`=1. Required: `in_ready`=1 throughout; `out_valid`=8'h40 and `out_data`=5 exactly one cycle later; `out_valid`=0 the cycle after.
- **Streaming and order.** Drive 8 back-to-back beats rotating `in_sel` through 8'h01..8'h80, data 0..7. Required: one output per cycle, in order, `out_valid` matching each sel, no `in_ready` deassertion.
- **Stall and skid.** Hold `out_ready`=0 and send 3 beats. Required: `in_ready` drops after 2 accepted beats and the third is held. Then set `out_ready`=8'hFF. Required: beats drain in order, one per cycle, and the third is accepted the cycle `in_ready` returns.
- **Illegal select.** Send `in_sel`=8'h00, then 8'h11, then a legal 8'h02 beat. Required: two `err_pulse` cycles; `err_cnt`=2; only the legal beat appears, on channel 1.
- **Wrong-channel ready and reset.** With `out_valid`=8'h04 stalled, drive `out_ready`=8'hFB. Required: no acceptance. Then pulse `rst_n` low mid-stall. Required: `out_valid`=0, `in_ready`=1, `err_cnt`=0 immediately (asynchronous).
- **Counter saturation.** With `CNT_WIDTH`=2, send 5 illegal beats. Required: `err_cnt` stops at 3; `err_pulse` fires 5 times.
